consolidate_sequencer: RTL
==========================

// Module: consolidate_sequencer
// PURPOSE
//  Top-level controller for architectural register consolidation ahead of a core reconfiguration.
//  On a reconfig request it stalls fetch and waits for the pipeline to drain.
//  It then pulses the register-consolidation unit's start, waits for its done, settles, and releases the core.
//  Drain and consolidation phases are both watchdog-protected; a timeout parks the block in a sticky error state.
// PARAMETERS
//  DRAIN_STABLE   2     consecutive cycles pipeDrained_i must be high before start (1..15)
//  DRAIN_TIMEOUT  1024  max cycles spent in DRAIN before error (1..65535)
//  CONS_TIMEOUT   256   max cycles spent in WAIT_DONE before error (1..65535)
//  SETTLE_CYCLES  2     idle cycles after done before release, to cover PRF write-back (1..255)
// PORTS
//  clk                 in   1  clock
//  reset               in   1  asynchronous, active-high reset
//  reconfigReq_i       in   1  level; request consolidation, sampled only in IDLE
//  reconfigAbort_i     in   1  cancel request; honoured only in DRAIN
//  pipeDrained_i       in   1  ROB/IQ/LSQ empty, no in-flight writes
//  doneConsolidate_i   in   1  one-cycle pulse from the consolidation unit
//  errorClear_i        in   1  pulse; leave ERROR
//  stallFetch_o        out  1  hold fetch/rename
//  startConsolidate_o  out  1  one-cycle start pulse to the consolidation unit
//  consolidateBusy_o   out  1  high in START, WAIT_DONE and SETTLE
//  reconfigDone_o      out  1  one-cycle completion pulse
//  error_o             out  1  high while in ERROR
//  errorCode_o         out  2  0 = none, 1 = drain timeout, 2 = consolidation timeout; held in ERROR
// BEHAVIOUR
//  - All outputs are Moore, decoded from the registered state. Reset sets state=IDLE, counters=0, all outputs=0.
//  - Reset is asynchronous: asserting it mid-operation drops stallFetch_o immediately.
//    The consolidation unit shares the same reset.
//  - One 16-bit phase counter (cnt) and one 4-bit stability counter (stab). cnt clears on every state change.
//  - IDLE: all outputs 0. reconfigReq_i=1 -> DRAIN.
//  - DRAIN: stallFetch_o=1; cnt++ each cycle.
//    stab++ while pipeDrained_i=1; stab clears when pipeDrained_i=0. stab saturates at DRAIN_STABLE.
//    Priority within a cycle is abort > stable > timeout:
//      reconfigAbort_i=1 -> IDLE, with no done pulse;
//      otherwise stab==DRAIN_STABLE-1 with pipeDrained_i=1 -> START;
//      otherwise cnt==DRAIN_TIMEOUT-1 -> ERROR, errorCode=1.
//  - START: exactly 1 cycle. stallFetch_o=1, startConsolidate_o=1, busy=1 -> WAIT_DONE.
//  - WAIT_DONE: stallFetch_o=1, busy=1, cnt++.
//    doneConsolidate_i=1 -> SETTLE; done wins over a same-cycle timeout.
//    Otherwise cnt==CONS_TIMEOUT-1 -> ERROR, errorCode=2.
//  - SETTLE: stallFetch_o=1, busy=1; cnt==SETTLE_CYCLES-1 -> DONE.
//  - DONE: exactly 1 cycle. reconfigDone_o=1, stallFetch_o=1 -> IDLE. Fetch is released the cycle after DONE.
//  - ERROR: error_o=1; errorCode_o held; stallFetch_o=0. errorClear_i -> IDLE, errorCode cleared.
//  - Inputs that are ignored:
//    doneConsolidate_i outside WAIT_DONE; reconfigReq_i outside IDLE; reconfigAbort_i outside DRAIN.
//  - reconfigReq_i still high in the cycle after DONE starts a new sequence (level-sensitive).
//  - Minimum latency, request to reconfigDone_o:
//    DRAIN_STABLE + 1 + (unit latency) + SETTLE_CYCLES + 1 cycles.
//  - Assertion: startConsolidate_o never high for 2 consecutive cycles.
// TESTING
//  1. Nominal: drained=1 throughout; done 70 cycles after start.
//     -> start pulse in cycle 3; done pulse at start+70+3; stall high from cycle 1 through DONE.
//  2. Drain glitch: drained pattern 1,0,1,1.
//     -> start pulses only after the second consecutive 1; stab resets on the 0.
//  3. Abort: abort in the 5th DRAIN cycle, same cycle as drained reaches stable.
//     -> IDLE; no start pulse; no done pulse; stall low the next cycle.
//  4. Drain timeout: DRAIN_TIMEOUT=8, drained=0.
//     -> ERROR after 8 DRAIN cycles; errorCode=1; stall=0.
//     errorClear -> IDLE, errorCode=0.
//  5. Consolidation timeout: CONS_TIMEOUT=16, done never arrives -> errorCode=2.
//     Repeat with done in exactly the 16th cycle -> SETTLE, no error.
//  6. Reset mid-WAIT_DONE: stall and busy drop asynchronously; a late done pulse is ignored; IDLE retained.

Source files
------------

// File: rtl/consolidate_sequencer_if.sv
// Handshake bundle between core, consolidation unit and the consolidation sequencer.
// The sequencer takes the slave view; the driving environment takes the master view.
interface consolidate_sequencer_if;
  logic       reconfigReq_i;
  logic       reconfigAbort_i;
  logic       pipeDrained_i;
  logic       doneConsolidate_i;
  logic       errorClear_i;
  logic       stallFetch_o;
  logic       startConsolidate_o;
  logic       consolidateBusy_o;
  logic       reconfigDone_o;
  logic       error_o;
  logic [1:0] errorCode_o;

  modport master (
    output reconfigReq_i, reconfigAbort_i, pipeDrained_i, doneConsolidate_i, errorClear_i,
    input  stallFetch_o, startConsolidate_o, consolidateBusy_o, reconfigDone_o, error_o, errorCode_o
  );

  modport slave (
    input  reconfigReq_i, reconfigAbort_i, pipeDrained_i, doneConsolidate_i, errorClear_i,
    output stallFetch_o, startConsolidate_o, consolidateBusy_o, reconfigDone_o, error_o, errorCode_o
  );
endinterface

// File: rtl/consolidate_sequencer.sv
// Sequences fetch stall, pipeline drain, register consolidation and core release for a
// reconfiguration, with watchdogs on the drain and consolidation phases.
module consolidate_sequencer #(
  parameter int unsigned DRAIN_STABLE  = 2,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CONS_TIMEOUT  = 256,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                    clk,
  input logic                    reset,
  consolidate_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [15:0] CONS_LAST   = 16'(CONS_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  STAB_MAX    = 4'(DRAIN_STABLE);
  localparam logic [3:0]  STAB_LAST   = 4'(DRAIN_STABLE - 1);

  state_t      state_r;
  state_t      next_s;
  logic [15:0] cnt_r;
  logic [3:0]  stab_r;
  logic [1:0]  errorCode_r;
  logic [1:0]  nextCode_s;
  logic        stall_r;
  logic        start_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;

  // Next-state and error-code selection; abort beats stability beats timeout in DRAIN.
  always_comb begin
    next_s     = state_r;
    nextCode_s = errorCode_r;
    case (state_r)
      IDLE: begin
        if (bus.reconfigReq_i) next_s = DRAIN;
        else                   next_s = IDLE;
      end
      DRAIN: begin
        if (bus.reconfigAbort_i) begin
          next_s = IDLE;
        end else if (bus.pipeDrained_i && (stab_r == STAB_LAST)) begin
          next_s = START;
        end else if (cnt_r == DRAIN_LAST) begin
          next_s     = ERROR;
          nextCode_s = 2'd1;
        end else begin
          next_s = DRAIN;
        end
      end
      START: next_s = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.doneConsolidate_i) begin
          next_s = SETTLE;
        end else if (cnt_r == CONS_LAST) begin
          next_s     = ERROR;
          nextCode_s = 2'd2;
        end else begin
          next_s = WAIT_DONE;
        end
      end
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) next_s = DONE;
        else                      next_s = SETTLE;
      end
      DONE: next_s = IDLE;
      ERROR: begin
        if (bus.errorClear_i) begin
          next_s     = IDLE;
          nextCode_s = 2'd0;
        end else begin
          next_s = ERROR;
        end
      end
      default: begin
        next_s     = IDLE;
        nextCode_s = 2'd0;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the state being entered so they
  // line up with the registered state while still coming straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      stab_r      <= 4'd0;
      errorCode_r <= 2'd0;
      stall_r     <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= next_s;
      errorCode_r <= nextCode_s;

      if (next_s != state_r) begin
        cnt_r <= 16'd0;
      end else if ((state_r == DRAIN) || (state_r == WAIT_DONE) || (state_r == SETTLE)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      // Stability only accumulates while staying in DRAIN; any gap in drained restarts it.
      if ((state_r == DRAIN) && (next_s == DRAIN) && bus.pipeDrained_i) begin
        if (stab_r < STAB_MAX) stab_r <= stab_r + 4'd1;
        else                   stab_r <= stab_r;
      end else begin
        stab_r <= 4'd0;
      end

      stall_r <= (next_s == DRAIN) || (next_s == START) || (next_s == WAIT_DONE) ||
                 (next_s == SETTLE) || (next_s == DONE);
      start_r <= (next_s == START);
      busy_r  <= (next_s == START) || (next_s == WAIT_DONE) || (next_s == SETTLE);
      done_r  <= (next_s == DONE);
      error_r <= (next_s == ERROR);
    end
  end

  assign bus.stallFetch_o       = stall_r;
  assign bus.startConsolidate_o = start_r;
  assign bus.consolidateBusy_o  = busy_r;
  assign bus.reconfigDone_o     = done_r;
  assign bus.error_o            = error_r;
  assign bus.errorCode_o        = errorCode_r;
endmodule
